mem_arbiter: RTL

Two-master arbiter for the single 8-bit memory bus. It shares the bus between master 0 (the core) and master 1 (a loader/DMA/debug port) and drives the SRAM-side bus. Arbitration is round-robin with bus parking and a bounded lock for multi-byte transfers. It sits between the core's m_* bus and the memory; each master sees the same cs/we/addr/wait protocol the core uses today.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter for the 8-bit memory bus
// The bus is parked on its last owner; a lock keeps ownership for at most LOCK_MAX blocked cycles.
module mem_arbiter #(
    parameter int LOCK_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cs_i,
    input  logic        m0_we_i,
    input  logic [15:0] m0_addr_i,
    input  logic [7:0]  m0_wdata_i,
    input  logic        m0_lock_i,
    output logic [7:0]  m0_rdata_o,
    output logic        m0_wait_o,
    input  logic        m1_cs_i,
    input  logic        m1_we_i,
    input  logic [15:0] m1_addr_i,
    input  logic [7:0]  m1_wdata_i,
    input  logic        m1_lock_i,
    output logic [7:0]  m1_rdata_o,
    output logic        m1_wait_o,
    output logic        s_cs_o,
    output logic        s_we_o,
    output logic [15:0] s_addr_o,
    output logic [7:0]  s_wdata_o,
    input  logic [7:0]  s_rdata_i,
    input  logic        s_wait_i,
    output logic        owner_o
);

    localparam int HW = $clog2(LOCK_MAX + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LOCK_MAX);

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    owner_e        owner_q, owner_d;
    logic [HW-1:0] hold_q, hold_d;

    logic        cs_own, we_own, lock_own, cs_other;
    logic [15:0] addr_own;
    logic [7:0]  wdata_own;
    logic        inflight, at_max;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= OWN_M0;
            hold_q  <= '0;
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        cs_own    = m0_cs_i;
        we_own    = m0_we_i;
        lock_own  = m0_lock_i;
        addr_own  = m0_addr_i;
        wdata_own = m0_wdata_i;
        cs_other  = m1_cs_i;
        if (owner_q == OWN_M1) begin
            cs_own    = m1_cs_i;
            we_own    = m1_we_i;
            lock_own  = m1_lock_i;
            addr_own  = m1_addr_i;
            wdata_own = m1_wdata_i;
            cs_other  = m0_cs_i;
        end
        inflight = cs_own & s_wait_i;
        at_max   = (hold_q == HOLD_MAX);
    end

    // A locked owner keeps the bus until the peer has been blocked LOCK_MAX cycles.
    always_comb begin
        owner_d = owner_q;
        hold_d  = hold_q;
        if (!cs_other) begin
            hold_d = '0;
        end else if (!inflight) begin
            if (!lock_own || at_max) begin
                owner_d = (owner_q == OWN_M0) ? OWN_M1 : OWN_M0;
                hold_d  = '0;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_comb begin
        s_cs_o     = 1'b0;
        s_we_o     = 1'b0;
        s_addr_o   = 16'h0000;
        s_wdata_o  = 8'h00;
        m0_wait_o  = 1'b1;
        m1_wait_o  = 1'b1;
        m0_rdata_o = 8'h00;
        m1_rdata_o = 8'h00;
        owner_o    = 1'b0;
        if (!rst_i) begin
            s_cs_o    = cs_own;
            s_we_o    = cs_own & we_own;
            s_addr_o  = addr_own;
            s_wdata_o = wdata_own;
            owner_o   = (owner_q == OWN_M1);
            if (owner_q == OWN_M1) begin
                m1_wait_o  = s_wait_i;
                m1_rdata_o = s_rdata_i;
            end else begin
                m0_wait_o  = s_wait_i;
                m0_rdata_o = s_rdata_i;
            end
        end
    end

endmodule
